// File: rtl/add_m.sv
// Registered packed-SIMD signed adder: LANES independent WIDTH-bit lanes,
// wrap or clamp on overflow, one register stage, any-lane overflow flag.

// One lane: combinational signed add with overflow detect and optional clamp.
module add_m_lane #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             o
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] clamp;

  assign sum = a + b;
  // Same-sign operands producing an opposite-sign sum is the only overflow case.
  assign o   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  // Negative operands clamp to the most negative value, positive to the most positive.
  assign clamp = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign res = ((SATURATE != 0) && o) ? clamp : sum;
endmodule

module add_m #(
  parameter int LANES    = 5,
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*WIDTH-1:0] m1,
  input  logic [LANES*WIDTH-1:0] m2,
  output logic [LANES*WIDTH-1:0] m_out,
  output logic                   ovf
);
  logic [LANES-1:0][WIDTH-1:0] a_v, b_v, res_v;
  logic [LANES-1:0]            lane_ovf;

  // Lane i sits at bits [WIDTH*i +: WIDTH]; the packed view matches that order.
  assign a_v = m1;
  assign b_v = m2;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    add_m_lane #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_lane (
      .a   (a_v[i]),
      .b   (b_v[i]),
      .res (res_v[i]),
      .o   (lane_ovf[i])
    );
  end

  // Output register; ovf reflects only the operation now on m_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_out <= '0;
      ovf   <= 1'b0;
    end else begin
      m_out <= res_v;
      ovf   <= |lane_ovf;
    end
  end
endmodule

// File: tb/tb_add_m.sv
// Bench for add_m: directed vectors plus randomized stimulus against an
// integer-arithmetic reference model, on a wrap and a saturating instance.
module tb_add_m;
  localparam int LANES = 5;
  localparam int WIDTH = 8;
  localparam int W     = LANES * WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] m1, m2;
  logic [W-1:0] out_w, out_s;
  logic         ovf_w, ovf_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_m #(.LANES(LANES), .WIDTH(WIDTH), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .m1(m1), .m2(m2), .m_out(out_w), .ovf(ovf_w));
  add_m #(.LANES(LANES), .WIDTH(WIDTH), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .m1(m1), .m2(m2), .m_out(out_s), .ovf(ovf_s));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer add per lane, range-checked against the
  // representable interval, then wrapped or clamped.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sat,
                       output logic [W-1:0] res, output logic o);
    int lo, hi;
    lo = -(1 << (WIDTH-1));
    hi = (1 << (WIDTH-1)) - 1;
    res = '0;
    o   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      int x, y, s, r;
      x = int'($signed(a[i*WIDTH +: WIDTH]));
      y = int'($signed(b[i*WIDTH +: WIDTH]));
      s = x + y;
      if (s > hi || s < lo) o = 1'b1;
      if (sat && s > hi)      r = hi;
      else if (sat && s < lo) r = lo;
      else                    r = s;
      res[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
    end
  endtask

  // Apply one vector for one edge and check both instances after the edge.
  task automatic step(input string tag, input logic r, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ew, es;
    logic         ow, os;
    rst = r; m1 = a; m2 = b;
    @(posedge clk); #1;
    if (r) begin
      ew = '0; es = '0; ow = 1'b0; os = 1'b0;
    end else begin
      model(a, b, 1'b0, ew, ow);
      model(a, b, 1'b1, es, os);
    end
    chk({tag, "_out"},  64'(out_w), 64'(ew));
    chk({tag, "_ovf"},  64'(ovf_w), 64'(ow));
    chk({tag, "_sout"}, 64'(out_s), 64'(es));
    chk({tag, "_sovf"}, 64'(ovf_s), 64'(os));
  endtask

  function automatic logic [WIDTH-1:0] pick_lane();
    logic [WIDTH-1:0] edges [6];
    edges = '{8'h7F, 8'h80, 8'hFF, 8'h00, 8'h01, 8'h81};
    if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 5)];
    return WIDTH'($urandom);
  endfunction

  function automatic logic [W-1:0] pick_word();
    logic [W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = pick_lane();
    return v;
  endfunction

  localparam logic [W-1:0] POS_A = 40'h0A141E2832, POS_B = 40'h050F19232D;
  localparam logic [W-1:0] MIX_A = 40'h0AEC1ED832, MIX_B = 40'hFB0FE723D3;
  localparam logic [W-1:0] OVF_A = 40'h649C7F8032, OVF_B = 40'h1E1E01FF9C;

  initial begin
    rst = 1'b1; m1 = '0; m2 = '0;

    // Reset held with arbitrary operands.
    for (int i = 0; i < 5; i++) step("rst_hold", 1'b1, pick_word(), pick_word());

    // Directed vectors with hand-computed constants.
    step("pos", 1'b0, POS_A, POS_B);
    chk("pos_const", 64'(out_w), 64'h0F23374B5F);
    chk("pos_const_ovf", 64'(ovf_w), 64'd0);
    step("mix", 1'b0, MIX_A, MIX_B);
    chk("mix_const", 64'(out_w), 64'h05FB05FB05);
    step("ovf", 1'b0, OVF_A, OVF_B);
    chk("ovf_wrap_const", 64'(out_w), 64'h82BA807FCE);
    chk("ovf_flag_const", 64'(ovf_w), 64'd1);
    chk("ovf_sat_const", 64'(out_s), 64'h7FBA7F80CE);
    chk("ovf_sat_flag_const", 64'(ovf_s), 64'd1);
    // Back-to-back: overflow clears on the next clean operation.
    step("clear", 1'b0, POS_A, POS_B);
    chk("clear_flag_const", 64'(ovf_w), 64'd0);
    // Mid-stream reset, then restart.
    step("ovf2", 1'b0, OVF_A, OVF_B);
    step("mid_rst", 1'b1, OVF_A, OVF_B);
    chk("mid_rst_const", 64'(out_w), 64'd0);
    step("restart", 1'b0, OVF_A, OVF_B);

    // Randomized stream with occasional reset pulses.
    for (int n = 0; n < 300; n++)
      step("rnd", ($urandom_range(0, 31) == 0), pick_word(), pick_word());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus thread never completes.
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
